// File: rtl/packConv.sv
// Shared conversion-datapath constants.
package packConv;

    localparam int unsigned NBITS = 16;

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Operand-vector in / result out handshake bundle for csa_tree_pipe.
interface csa_tree_pipe_if #(
    parameter int unsigned NOPS  = 9,
    parameter int unsigned NBITS = packConv::NBITS
);

    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] ops [NOPS];
    logic             acc_en;
    logic             acc_last;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_sum;

    modport master (
        output in_valid, ops, acc_en, acc_last, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, ops, acc_en, acc_last, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save adder tree with optional group accumulation.
// One input register, one register per 3:2 layer, then a carry-propagate
// add/accumulate stage; the whole pipe freezes while a result is unread.
module csa_tree_pipe #(
    parameter int unsigned NOPS  = 9,
    parameter int unsigned NBITS = packConv::NBITS
) (
    input  logic           clock,
    input  logic           reset_n,
    csa_tree_pipe_if.slave bus
);

    // Operand count after one 3:2 layer.
    function automatic int unsigned next_n(input int unsigned n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Operand count entering layer k.
    function automatic int unsigned ops_at(input int unsigned k);
        int unsigned n = NOPS;
        for (int unsigned i = 0; i < k; i++) begin
            n = next_n(n);
        end
        return n;
    endfunction

    // Number of 3:2 layers needed to reach two words.
    function automatic int unsigned layer_count();
        int unsigned n = NOPS;
        int unsigned c = 0;
        while (n > 2) begin
            n = next_n(n);
            c++;
        end
        return c;
    endfunction

    localparam int unsigned NLAYERS = layer_count();

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    logic stall_c;

    assign stall_c      = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall_c;

    // Input register stage.
    logic [NBITS-1:0] in_word_d [NOPS];
    logic [NBITS-1:0] in_word_q [NOPS];
    logic             in_vld_d, in_vld_q;
    logic             in_en_d, in_en_q;
    logic             in_last_d, in_last_q;

    // Capture the operand vector on accept, hold on stall.
    always_comb begin
        in_word_d = in_word_q;
        in_vld_d  = in_vld_q;
        in_en_d   = in_en_q;
        in_last_d = in_last_q;
        if (!stall_c) begin
            in_word_d = bus.ops;
            in_vld_d  = bus.in_valid;
            in_en_d   = bus.acc_en;
            in_last_d = bus.acc_last;
        end
    end

    // Input stage registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NOPS); i++) begin
                in_word_q[i] <= '0;
            end
            in_vld_q  <= 1'b0;
            in_en_q   <= 1'b0;
            in_last_q <= 1'b0;
        end else begin
            in_word_q <= in_word_d;
            in_vld_q  <= in_vld_d;
            in_en_q   <= in_en_d;
            in_last_q <= in_last_d;
        end
    end

    logic [NBITS-1:0] fin_a, fin_b;
    logic             fin_vld, fin_en, fin_last;

    for (genvar k = 0; k < int'(NLAYERS); k++) begin : g_layer
        localparam int unsigned NI = ops_at(k);
        localparam int unsigned NO = ops_at(k + 1);
        localparam int unsigned NG = NI / 3;

        logic [NBITS-1:0] word_i [NI];
        logic             vld_i, en_i, last_i;
        logic [NBITS-1:0] word_d [NO];
        logic [NBITS-1:0] word_q [NO];
        logic             vld_d, vld_q;
        logic             en_d, en_q;
        logic             last_d, last_q;

        if (k == 0) begin : g_src
            // Layer 0 is fed from the input register.
            always_comb begin
                word_i = in_word_q;
                vld_i  = in_vld_q;
                en_i   = in_en_q;
                last_i = in_last_q;
            end
        end else begin : g_src
            // Later layers are fed from the previous layer register.
            always_comb begin
                word_i = g_layer[k-1].word_q;
                vld_i  = g_layer[k-1].vld_q;
                en_i   = g_layer[k-1].en_q;
                last_i = g_layer[k-1].last_q;
            end
        end

        // One 3:2 layer: triples compress to sum/carry, leftovers pass through.
        always_comb begin
            word_d = word_q;
            vld_d  = vld_q;
            en_d   = en_q;
            last_d = last_q;
            if (!stall_c) begin
                vld_d  = vld_i;
                en_d   = en_i;
                last_d = last_i;
                for (int g = 0; g < int'(NG); g++) begin
                    word_d[2*g]   = word_i[3*g] ^ word_i[3*g+1] ^ word_i[3*g+2];
                    word_d[2*g+1] = ((word_i[3*g]   & word_i[3*g+1]) |
                                     (word_i[3*g]   & word_i[3*g+2]) |
                                     (word_i[3*g+1] & word_i[3*g+2])) << 1;
                end
                for (int r = 0; r < int'(NI - 3 * NG); r++) begin
                    word_d[2*int'(NG) + r] = word_i[3*int'(NG) + r];
                end
            end
        end

        // Layer registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(NO); i++) begin
                    word_q[i] <= '0;
                end
                vld_q  <= 1'b0;
                en_q   <= 1'b0;
                last_q <= 1'b0;
            end else begin
                word_q <= word_d;
                vld_q  <= vld_d;
                en_q   <= en_d;
                last_q <= last_d;
            end
        end
    end

    if (NLAYERS == 0) begin : g_fin_src
        assign fin_a    = in_word_q[0];
        assign fin_b    = in_word_q[1];
        assign fin_vld  = in_vld_q;
        assign fin_en   = in_en_q;
        assign fin_last = in_last_q;
    end else begin : g_fin_src
        assign fin_a    = g_layer[NLAYERS-1].word_q[0];
        assign fin_b    = g_layer[NLAYERS-1].word_q[1];
        assign fin_vld  = g_layer[NLAYERS-1].vld_q;
        assign fin_en   = g_layer[NLAYERS-1].en_q;
        assign fin_last = g_layer[NLAYERS-1].last_q;
    end

    acc_state_e       state_d, state_q;
    logic [NBITS-1:0] acc_d, acc_q;
    logic [NBITS-1:0] out_sum_d, out_sum_q;
    logic             out_valid_d, out_valid_q;
    logic [NBITS-1:0] tree_sum_c;

    assign tree_sum_c = fin_a + fin_b;

    // Final stage: carry-propagate add, group accumulation and result register.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        if (!stall_c && fin_vld) begin
            if (!fin_en) begin
                out_sum_d   = tree_sum_c;
                out_valid_d = 1'b1;
            end else if (!fin_last) begin
                acc_d   = (state_q == ST_ACC) ? acc_q + tree_sum_c : tree_sum_c;
                state_d = ST_ACC;
            end else begin
                out_sum_d   = ((state_q == ST_ACC) ? acc_q : '0) + tree_sum_c;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
        end
    end

    // Final stage registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: directed latency/accumulate/stall/reset cases and
// a randomized run, all scored against a sum-of-operands group model.
module tb_csa_tree_pipe;

    localparam int unsigned NB = 16;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    csa_tree_pipe_if #(.NOPS(9),  .NBITS(NB)) bus9  ();
    csa_tree_pipe_if #(.NOPS(2),  .NBITS(NB)) bus2  ();
    csa_tree_pipe_if #(.NOPS(3),  .NBITS(NB)) bus3  ();
    csa_tree_pipe_if #(.NOPS(16), .NBITS(NB)) bus16 ();

    csa_tree_pipe #(.NOPS(9),  .NBITS(NB)) dut9  (.clock(clock), .reset_n(reset_n), .bus(bus9));
    csa_tree_pipe #(.NOPS(2),  .NBITS(NB)) dut2  (.clock(clock), .reset_n(reset_n), .bus(bus2));
    csa_tree_pipe #(.NOPS(3),  .NBITS(NB)) dut3  (.clock(clock), .reset_n(reset_n), .bus(bus3));
    csa_tree_pipe #(.NOPS(16), .NBITS(NB)) dut16 (.clock(clock), .reset_n(reset_n), .bus(bus16));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: results in acceptance order, plus open-group state.
    logic [NB-1:0] exp_q [$];
    bit            grp_open = 1'b0;
    logic [NB-1:0] grp_acc  = '0;
    bit            hold_prev = 1'b0;
    logic [NB-1:0] sum_prev  = '0;

    // Scoreboard / protocol monitor on the 9-operand instance.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            grp_open  = 1'b0;
            grp_acc   = '0;
            hold_prev = 1'b0;
        end else begin
            int unsigned s;
            logic [NB-1:0] beat;
            check_eq("in_ready", 32'(bus9.in_ready), 32'(!(bus9.out_valid && !bus9.out_ready)));
            if (hold_prev) begin
                check_eq("stall_valid", 32'(bus9.out_valid), 32'd1);
                check_eq("stall_hold", 32'(bus9.out_sum), 32'(sum_prev));
            end
            if (bus9.out_valid && bus9.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("sb_data", 32'(bus9.out_sum), 32'(exp_q.pop_front()));
                end
            end
            hold_prev = bus9.out_valid && !bus9.out_ready;
            sum_prev  = bus9.out_sum;
            if (bus9.in_valid && bus9.in_ready) begin
                s = 0;
                for (int i = 0; i < 9; i++) begin
                    s += 32'(bus9.ops[i]);
                end
                beat = NB'(s);
                if (!bus9.acc_en) begin
                    exp_q.push_back(beat);
                end else if (!bus9.acc_last) begin
                    grp_acc  = grp_open ? grp_acc + beat : beat;
                    grp_open = 1'b1;
                end else begin
                    exp_q.push_back((grp_open ? grp_acc : NB'(0)) + beat);
                    grp_open = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input logic [NB-1:0] v);
        for (int i = 0; i < 9; i++) begin
            bus9.ops[i] = v;
        end
    endtask

    task automatic drive_idle();
        bus9.in_valid = 1'b0;
        bus9.acc_en   = 1'b0;
        bus9.acc_last = 1'b0;
    endtask

    // Present one beat and hold it until accepted.
    task automatic send_beat(input logic [NB-1:0] v, input logic en, input logic last);
        int n = 0;
        set_ops(v);
        bus9.acc_en   = en;
        bus9.acc_last = last;
        bus9.in_valid = 1'b1;
        while (!bus9.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("send_timeout", 32'(n), 32'd0);
        tick();
        drive_idle();
    endtask

    // Wait (bounded) for a result and compare it.
    task automatic wait_out(input string tag, input logic [NB-1:0] exp, input int max);
        int n = 0;
        while (!bus9.out_valid && n < max) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bus9.out_valid), 32'd1);
        check_eq({tag, "_sum"}, 32'(bus9.out_sum), 32'(exp));
    endtask

    // Single all-ones beat into every instance; result exactly L edges later.
    task automatic lat_test();
        for (int i = 0; i < 9; i++)  bus9.ops[i]  = NB'(1);
        for (int i = 0; i < 2; i++)  bus2.ops[i]  = NB'(1);
        for (int i = 0; i < 3; i++)  bus3.ops[i]  = NB'(1);
        for (int i = 0; i < 16; i++) bus16.ops[i] = NB'(1);
        bus9.in_valid  = 1'b1;
        bus2.in_valid  = 1'b1;
        bus3.in_valid  = 1'b1;
        bus16.in_valid = 1'b1;
        tick();
        bus9.in_valid  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus3.in_valid  = 1'b0;
        bus16.in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check_eq($sformatf("lat9_v%0d", c),  32'(bus9.out_valid),  32'(c == 5));
            check_eq($sformatf("lat2_v%0d", c),  32'(bus2.out_valid),  32'(c == 1));
            check_eq($sformatf("lat3_v%0d", c),  32'(bus3.out_valid),  32'(c == 2));
            check_eq($sformatf("lat16_v%0d", c), 32'(bus16.out_valid), 32'(c == 7));
            if (c == 5) check_eq("lat9_sum",  32'(bus9.out_sum),  32'd9);
            if (c == 1) check_eq("lat2_sum",  32'(bus2.out_sum),  32'd2);
            if (c == 2) check_eq("lat3_sum",  32'(bus3.out_sum),  32'd3);
            if (c == 7) check_eq("lat16_sum", 32'(bus16.out_sum), 32'd16);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        drive_idle();
        set_ops('0);
        bus9.out_ready = 1'b1;
        foreach (bus2.ops[i])  bus2.ops[i]  = '0;
        foreach (bus3.ops[i])  bus3.ops[i]  = '0;
        foreach (bus16.ops[i]) bus16.ops[i] = '0;
        bus2.in_valid  = 1'b0; bus2.acc_en  = 1'b0; bus2.acc_last  = 1'b0; bus2.out_ready  = 1'b1;
        bus3.in_valid  = 1'b0; bus3.acc_en  = 1'b0; bus3.acc_last  = 1'b0; bus3.out_ready  = 1'b1;
        bus16.in_valid = 1'b0; bus16.acc_en = 1'b0; bus16.acc_last = 1'b0; bus16.out_ready = 1'b1;

        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus9.out_valid), 32'd0);
        check_eq("rst_out_sum",   32'(bus9.out_sum),   32'd0);
        check_eq("rst_in_ready",  32'(bus9.in_ready),  32'd1);
        check_eq("rst_v16",       32'(bus16.out_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Latency at NOPS = 9, 2, 3, 16 with first accept right after reset.
        lat_test();

        // Wrap cases.
        send_beat(16'hFFFF, 1'b0, 1'b0);
        wait_out("all_ffff", 16'hFFF7, 10);
        send_beat(16'h8000, 1'b0, 1'b0);
        wait_out("all_8000", 16'h8000, 10);
        tick();

        // Back-to-back stream with no gaps.
        fork
            begin
                for (int i = 1; i <= 20; i++) begin
                    set_ops(NB'(i));
                    bus9.in_valid = 1'b1;
                    tick();
                end
                drive_idle();
            end
            begin
                int n = 0;
                while (!bus9.out_valid && n < 30) begin
                    tick();
                    n++;
                end
                for (int i = 1; i <= 20; i++) begin
                    check_eq($sformatf("b2b_v%0d", i), 32'(bus9.out_valid), 32'd1);
                    check_eq($sformatf("b2b_s%0d", i), 32'(bus9.out_sum), 32'(9 * i));
                    tick();
                end
            end
        join
        tick();

        // Three-beat group, then a single-beat group.
        send_beat(16'd1, 1'b1, 1'b0);
        send_beat(16'd1, 1'b1, 1'b0);
        send_beat(16'd1, 1'b1, 1'b1);
        wait_out("acc3", 16'd27, 12);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq("acc3_extra", 32'(bus9.out_valid), 32'd0);
        end
        send_beat(16'd2, 1'b1, 1'b1);
        wait_out("acc_single", 16'd18, 10);
        tick();

        // Backpressure: hold the first result for three cycles.
        bus9.out_ready = 1'b0;
        send_beat(16'd3, 1'b0, 1'b0);
        send_beat(16'd4, 1'b0, 1'b0);
        send_beat(16'd5, 1'b0, 1'b0);
        send_beat(16'd6, 1'b0, 1'b0);
        wait_out("stall_first", 16'd27, 12);
        for (int c = 0; c < 3; c++) begin
            check_eq("stall_in_ready", 32'(bus9.in_ready), 32'd0);
            check_eq("stall_sum", 32'(bus9.out_sum), 32'd27);
            tick();
        end
        bus9.out_ready = 1'b1;
        tick();
        wait_out("stall_seq1", 16'd36, 3);
        tick();
        wait_out("stall_seq2", 16'd45, 3);
        tick();
        wait_out("stall_seq3", 16'd54, 3);
        tick();

        // Reset with an open group and three beats in flight.
        send_beat(16'd7, 1'b1, 1'b0);
        send_beat(16'd1, 1'b0, 1'b0);
        send_beat(16'd2, 1'b0, 1'b0);
        send_beat(16'd3, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(bus9.out_valid), 32'd0);
        check_eq("midrst_in_ready",  32'(bus9.in_ready),  32'd1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check_eq("post_rst_quiet", 32'(bus9.out_valid), 32'd0);
            tick();
        end
        lat_test();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            bus9.in_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 9; i++) begin
                bus9.ops[i] = NB'($urandom);
            end
            bus9.acc_en    = 1'($urandom_range(0, 1));
            bus9.acc_last  = ($urandom_range(0, 2) == 0);
            bus9.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive_idle();
        bus9.out_ready = 1'b1;
        repeat (20) tick();
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
